implication_window_checker: RTL and testbench

//  Multi-channel checker for the property antecedent |-> ##[DELAY_MIN:DELAY_MAX] consequent.
//  - Successor to the single-bit overlapping/non-overlapping checker.
//  - Overlapping case: DELAY_MIN=DELAY_MAX=0. Non-overlapping case: DELAY_MIN=DELAY_MAX=1.
//  - Tracks every outstanding antecedent thread explicitly and reports pass/fail pulses and counts.
//  - Sits beside any DUT in formal (SBY) or simulation benches; pure observer, drives no DUT signal.

---
 rtl/implication_pkg.sv | 17 +
 rtl/implication_window_channel.sv | 66 ++++++
 rtl/implication_window_checker.sv | 79 +++++++
 tb/tb_implication_window_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/implication_pkg.sv
// Shared types and limits for the antecedent |-> ##[min:max] consequent checker.
package implication_pkg;

    typedef enum logic {
        CONCURRENT,
        IMMEDIATE
    } assert_kind_e;

    typedef enum logic [1:0] {
        OVERLAPPING,
        NON_OVERLAPPING,
        RANGED
    } implication_kind_e;

    localparam int unsigned MAX_DELAY_LIMIT = 15;

endpackage

// File: rtl/implication_window_channel.sv
// One channel: tracks outstanding antecedent threads by age and flags discharge/expiry.
module implication_window_channel
    import implication_pkg::*;
#(
    parameter int unsigned DELAY_MIN = 0,
    parameter int unsigned DELAY_MAX = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic antecedent,
    input  logic consequent,
    output logic pending,
    output logic pass,
    output logic fail,
    output logic fail_now_c
);

    localparam int unsigned VW = DELAY_MAX + 1;
    // Ages below DELAY_MIN are too early to be discharged.
    localparam logic [VW-1:0] EARLY_MASK = VW'((64'd1 << DELAY_MIN) - 64'd1);
    localparam logic [VW-1:0] WIN_MASK   = ~EARLY_MASK;

    logic [VW-1:0] v;
    logic [VW-1:0] hit;

    always_comb begin
        hit        = v & WIN_MASK & {VW{consequent}};
        fail_now_c = v[DELAY_MAX] & ~consequent & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            pass <= |hit;
            fail <= fail_now_c;
        end
    end

    if (DELAY_MAX > 0) begin : g_obl
        logic [DELAY_MAX-1:0] obl_q;
        logic [DELAY_MAX-1:0] obl_d;

        assign v = {obl_q, antecedent};

        // Surviving threads age by one; the oldest one drops out (discharged or failed).
        always_comb begin
            obl_d = v[DELAY_MAX-1:0] & ~hit[DELAY_MAX-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                obl_q   <= '0;
                pending <= 1'b0;
            end else begin
                obl_q   <= obl_d;
                pending <= |obl_d;
            end
        end
    end else begin : g_no_obl
        assign v       = antecedent;
        assign pending = 1'b0;
    end

endmodule

// File: rtl/implication_window_checker.sv
// Multi-channel observer for antecedent |-> ##[DELAY_MIN:DELAY_MAX] consequent with fail accounting.
module implication_window_checker
    import implication_pkg::*;
#(
    parameter int unsigned  NUM_CH      = 1,
    parameter int unsigned  DELAY_MIN   = 0,
    parameter int unsigned  DELAY_MAX   = 0,
    parameter int unsigned  CNT_W       = 8,
    parameter assert_kind_e ASSERT_KIND = IMMEDIATE,
    parameter bit           ASSERT_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] antecedent,
    input  logic [NUM_CH-1:0] consequent,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] pass,
    output logic [NUM_CH-1:0] fail,
    output logic              sticky_fail,
    output logic [CNT_W-1:0]  fail_count
);

    localparam int unsigned     SUM_W   = CNT_W + $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (NUM_CH == 0 || DELAY_MIN > DELAY_MAX || DELAY_MAX > MAX_DELAY_LIMIT) begin : g_bad_params
        $error("implication_window_checker: illegal NUM_CH/DELAY_MIN/DELAY_MAX");
    end

    logic [NUM_CH-1:0] fail_now_c;
    logic [SUM_W-1:0]  count_sum;
    logic [CNT_W-1:0]  count_next;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        implication_window_channel #(
            .DELAY_MIN (DELAY_MIN),
            .DELAY_MAX (DELAY_MAX)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .antecedent (antecedent[ch]),
            .consequent (consequent[ch]),
            .pending    (pending[ch]),
            .pass       (pass[ch]),
            .fail       (fail[ch]),
            .fail_now_c (fail_now_c[ch])
        );
    end

    // Several channels can fail in one cycle; add them all, then clamp.
    always_comb begin
        count_sum  = SUM_W'(fail_count) + SUM_W'($countones(fail_now_c));
        count_next = (count_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_count  <= '0;
            sticky_fail <= 1'b0;
        end else begin
            fail_count  <= count_next;
            sticky_fail <= sticky_fail | (|fail_now_c);
        end
    end

    // An expiring thread is exactly a violated implication, so both forms track fail_now_c.
    if (ASSERT_EN) begin : g_assert
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch_assert
            if (ASSERT_KIND == IMMEDIATE) begin : g_imm
                always @(posedge clk) begin
                    if (!rst) assert (!fail_now_c[ch]);
                end
            end else begin : g_conc
                a_window : assert property (@(posedge clk) disable iff (rst) !fail_now_c[ch]);
            end
        end
    end

endmodule

// File: tb/tb_implication_window_checker.sv
// Directed bench: one checker instance per delay configuration, shared clock and reset.
module tb_implication_window_checker;
    import implication_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // DELAY 0/0
    logic       a00, k00, pend00, pass00, fail00, st00;
    logic [7:0] cnt00;
    // DELAY 1/1
    logic       a11, k11, pend11, pass11, fail11, st11;
    logic [7:0] cnt11;
    // DELAY 2/4
    logic       a24, k24, pend24, pass24, fail24, st24;
    logic [7:0] cnt24;
    // DELAY 1/3
    logic       a13, k13, pend13, pass13, fail13, st13;
    logic [7:0] cnt13;
    // 4 channels, DELAY 0/0, 2-bit counter
    logic [3:0] a4, k4, pend4, pass4, fail4;
    logic       st4;
    logic [1:0] cnt4;

    implication_window_checker #(.NUM_CH(1), .DELAY_MIN(0), .DELAY_MAX(0), .CNT_W(8),
        .ASSERT_KIND(IMMEDIATE), .ASSERT_EN(1'b0)) u_d00 (
        .clk(clk), .rst(rst), .antecedent(a00), .consequent(k00), .pending(pend00),
        .pass(pass00), .fail(fail00), .sticky_fail(st00), .fail_count(cnt00));

    implication_window_checker #(.NUM_CH(1), .DELAY_MIN(1), .DELAY_MAX(1), .CNT_W(8),
        .ASSERT_KIND(CONCURRENT), .ASSERT_EN(1'b0)) u_d11 (
        .clk(clk), .rst(rst), .antecedent(a11), .consequent(k11), .pending(pend11),
        .pass(pass11), .fail(fail11), .sticky_fail(st11), .fail_count(cnt11));

    implication_window_checker #(.NUM_CH(1), .DELAY_MIN(2), .DELAY_MAX(4), .CNT_W(8),
        .ASSERT_KIND(IMMEDIATE), .ASSERT_EN(1'b0)) u_d24 (
        .clk(clk), .rst(rst), .antecedent(a24), .consequent(k24), .pending(pend24),
        .pass(pass24), .fail(fail24), .sticky_fail(st24), .fail_count(cnt24));

    implication_window_checker #(.NUM_CH(1), .DELAY_MIN(1), .DELAY_MAX(3), .CNT_W(8),
        .ASSERT_KIND(IMMEDIATE), .ASSERT_EN(1'b0)) u_d13 (
        .clk(clk), .rst(rst), .antecedent(a13), .consequent(k13), .pending(pend13),
        .pass(pass13), .fail(fail13), .sticky_fail(st13), .fail_count(cnt13));

    implication_window_checker #(.NUM_CH(4), .DELAY_MIN(0), .DELAY_MAX(0), .CNT_W(2),
        .ASSERT_KIND(IMMEDIATE), .ASSERT_EN(1'b0)) u_d4 (
        .clk(clk), .rst(rst), .antecedent(a4), .consequent(k4), .pending(pend4),
        .pass(pass4), .fail(fail4), .sticky_fail(st4), .fail_count(cnt4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs then reflect the inputs of the cycle just sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a00 = 0; k00 = 0; a11 = 0; k11 = 0; a24 = 0; k24 = 0; a13 = 0; k13 = 0;
        a4 = '0; k4 = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        do_reset();
        check("rst_pass00", 32'(pass00), 32'd0);
        check("rst_fail00", 32'(fail00), 32'd0);
        check("rst_cnt00",  32'(cnt00),  32'd0);
        check("rst_st00",   32'(st00),   32'd0);
        check("rst_pend24", 32'(pend24), 32'd0);
        check("rst_fail4",  32'(fail4),  32'd0);

        // 1: overlapping, pass then fail
        tick(); tick();
        a00 = 1; k00 = 1;
        tick();
        check("t1_pass_c3", 32'(pass00), 32'd1);
        check("t1_fail_c3", 32'(fail00), 32'd0);
        a00 = 0; k00 = 0;
        tick();
        check("t1_pass_c4", 32'(pass00), 32'd0);
        tick();
        a00 = 1; k00 = 0;
        tick();
        check("t1_fail_c6", 32'(fail00), 32'd1);
        check("t1_pass_c6", 32'(pass00), 32'd0);
        check("t1_cnt_c6",  32'(cnt00),  32'd1);
        check("t1_st_c6",   32'(st00),   32'd1);
        a00 = 0;
        tick();
        check("t1_fail_c7", 32'(fail00), 32'd0);
        check("t1_cnt_c7",  32'(cnt00),  32'd1);

        // 2: non-overlapping from first post-reset cycle; too-early consequent
        do_reset();
        a11 = 1;
        tick();
        check("t2_pend_c1", 32'(pend11), 32'd1);
        check("t2_pass_c1", 32'(pass11), 32'd0);
        a11 = 0; k11 = 1;
        tick();
        check("t2_pass_c2", 32'(pass11), 32'd1);
        check("t2_fail_c2", 32'(fail11), 32'd0);
        check("t2_pend_c2", 32'(pend11), 32'd0);
        k11 = 0;
        tick(); tick();
        a11 = 1; k11 = 1;
        tick();
        check("t2_pass_c5", 32'(pass11), 32'd0);
        check("t2_pend_c5", 32'(pend11), 32'd1);
        a11 = 0; k11 = 0;
        tick();
        check("t2_fail_c6", 32'(fail11), 32'd1);
        check("t2_pass_c6", 32'(pass11), 32'd0);
        check("t2_cnt_c6",  32'(cnt11),  32'd1);

        // 3: ranged window, two threads discharged by one consequent
        do_reset();
        a24 = 1;
        tick();
        a24 = 1; k24 = 1;
        tick();
        check("t3_pass_c2", 32'(pass24), 32'd0);
        check("t3_pend_c2", 32'(pend24), 32'd1);
        a24 = 0; k24 = 0;
        tick();
        check("t3_pass_c3", 32'(pass24), 32'd0);
        check("t3_pend_c3", 32'(pend24), 32'd1);
        k24 = 1;
        tick();
        check("t3_pass_c4", 32'(pass24), 32'd1);
        check("t3_pend_c4", 32'(pend24), 32'd0);
        check("t3_fail_c4", 32'(fail24), 32'd0);
        k24 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_fail_late", 32'(fail24), 32'd0);
            check("t3_pass_late", 32'(pass24), 32'd0);
        end
        check("t3_cnt", 32'(cnt24), 32'd0);

        // 4: reset mid-flight drops the thread silently
        do_reset();
        a13 = 1;
        tick();
        check("t4_pend_c1", 32'(pend13), 32'd1);
        a13 = 0;
        tick();
        check("t4_pend_c2", 32'(pend13), 32'd1);
        rst = 1;
        tick();
        check("t4_pend_c3", 32'(pend13), 32'd0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_fail", 32'(fail13), 32'd0);
            check("t4_pass", 32'(pass13), 32'd0);
        end
        check("t4_cnt", 32'(cnt13), 32'd0);
        check("t4_st",  32'(st13),  32'd0);

        // 5: four channels, counter saturation, sticky until reset
        do_reset();
        a4 = 4'b0011; k4 = 4'b0000;
        tick();
        check("t5_fail_c1", 32'(fail4), 32'h3);
        check("t5_cnt_c1",  32'(cnt4),  32'd2);
        check("t5_st_c1",   32'(st4),   32'd1);
        a4 = 4'hF;
        tick();
        check("t5_fail_c2", 32'(fail4), 32'hF);
        check("t5_cnt_c2",  32'(cnt4),  32'd3);
        a4 = 4'b0101; k4 = 4'b0001;
        tick();
        check("t5_pass_c3", 32'(pass4), 32'h1);
        check("t5_fail_c3", 32'(fail4), 32'h4);
        check("t5_cnt_c3",  32'(cnt4),  32'd3);
        a4 = '0; k4 = '0;
        tick();
        check("t5_fail_c4", 32'(fail4), 32'h0);
        check("t5_pass_c4", 32'(pass4), 32'h0);
        check("t5_st_c4",   32'(st4),   32'd1);
        do_reset();
        check("t5_st_rst",  32'(st4),   32'd0);
        check("t5_cnt_rst", 32'(cnt4),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
